// File: rtl/shift_unit_arbiter.sv
// Round-robin sequencer sharing one left and one right 16-bit shifter between two requesters.
// Optional circular rotate is built in when SHIFT_ARB_ROTATE_EN is defined.
module shift_unit_arbiter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_dir,
`ifdef SHIFT_ARB_ROTATE_EN
    input  logic             req0_rot,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_dir,
`ifdef SHIFT_ARB_ROTATE_EN
    input  logic             req1_rot,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             sh_clk_en,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_lg;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_id;

    logic [WIDTH-1:0] r_op_data_p0;
    logic [AMT_W-1:0] r_op_amt_p0;
    logic             r_op_dir_p0;
    logic             r_op_id_p0;
`ifdef SHIFT_ARB_ROTATE_EN
    logic             r_op_rot_p0;
`endif

    logic             w_grant;
    logic             w_idle;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    logic [AMT_W-1:0] w_sel_amt;
    logic             w_sel_dir;
`ifdef SHIFT_ARB_ROTATE_EN
    logic             w_sel_rot;
`endif
    logic [WIDTH-1:0] w_shl_p1;
    logic [WIDTH-1:0] w_shr_p1;
    logic [WIDTH-1:0] w_result_p1;

    // Logical shifters; with rotate enabled the bits shifted out re-enter at the far end.
    // A complementary shift of WIDTH (amt=0) yields zero, so amt=0 passes the operand through.
`ifdef SHIFT_ARB_ROTATE_EN
    function automatic logic [WIDTH-1:0] f_shl(input logic [WIDTH-1:0] d,
                                               input logic [AMT_W-1:0] amt,
                                               input logic rot);
        logic [AMT_W:0]   inv;
        logic [WIDTH-1:0] res;
        inv = (AMT_W+1)'(WIDTH) - {1'b0, amt};
        res = d << amt;
        if (rot)
            res = res | (d >> inv);
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] f_shr(input logic [WIDTH-1:0] d,
                                               input logic [AMT_W-1:0] amt,
                                               input logic rot);
        logic [AMT_W:0]   inv;
        logic [WIDTH-1:0] res;
        inv = (AMT_W+1)'(WIDTH) - {1'b0, amt};
        res = d >> amt;
        if (rot)
            res = res | (d << inv);
        return res;
    endfunction
`else
    function automatic logic [WIDTH-1:0] f_shl(input logic [WIDTH-1:0] d,
                                               input logic [AMT_W-1:0] amt);
        return d << amt;
    endfunction

    function automatic logic [WIDTH-1:0] f_shr(input logic [WIDTH-1:0] d,
                                               input logic [AMT_W-1:0] amt);
        return d >> amt;
    endfunction
`endif

    // Grant favours the requester that did not win last time when both are pending.
    always_comb begin
        w_idle     = (r_state == S_IDLE);
        w_grant    = (req0_valid & req1_valid) ? ~r_lg : req1_valid;
        w_ready0   = w_idle & ~w_grant & req0_valid;
        w_ready1   = w_idle &  w_grant & req1_valid;
        w_accept   = w_ready0 | w_ready1;
        w_sel_data = w_grant ? req1_data : req0_data;
        w_sel_amt  = w_grant ? req1_amt  : req0_amt;
        w_sel_dir  = w_grant ? req1_dir  : req0_dir;
`ifdef SHIFT_ARB_ROTATE_EN
        w_sel_rot  = w_grant ? req1_rot  : req0_rot;
`endif
    end

    // p0: operand register, loaded only on accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_data_p0 <= w_sel_data;
            r_op_amt_p0  <= w_sel_amt;
            r_op_dir_p0  <= w_sel_dir;
            r_op_id_p0   <= w_grant;
`ifdef SHIFT_ARB_ROTATE_EN
            r_op_rot_p0  <= w_sel_rot;
`endif
        end
    end

    // p1: both shifters see the registered operand, direction picks one
    always_comb begin
`ifdef SHIFT_ARB_ROTATE_EN
        w_shl_p1 = f_shl(r_op_data_p0, r_op_amt_p0, r_op_rot_p0);
        w_shr_p1 = f_shr(r_op_data_p0, r_op_amt_p0, r_op_rot_p0);
`else
        w_shl_p1 = f_shl(r_op_data_p0, r_op_amt_p0);
        w_shr_p1 = f_shr(r_op_data_p0, r_op_amt_p0);
`endif
        w_result_p1 = r_op_dir_p0 ? w_shr_p1 : w_shl_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lg        <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lg    <= w_grant;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= w_result_p1;
                    r_rsp_id    <= r_op_id_p0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign sh_clk_en  = w_accept | (r_state == S_EXEC);
    assign busy       = r_busy;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;

endmodule
